// File: rtl/pwm_cfg_pkg.sv
// Shared types and helpers for the PWM configuration controller:
// run-state encoding, default widths and the commit-time clamp.
package pwm_cfg_pkg;

    localparam int DEF_W      = 32;
    localparam int DEF_DT_MAX = 255;
    // The clamp helper works at this width; W must not exceed it.
    localparam int CLAMP_W    = 64;

    typedef enum logic [1:0] {
        S_OFF,
        S_START,
        S_RUN,
        S_STOP
    } state_t;

    typedef struct packed {
        logic [CLAMP_W-1:0] period;
        logic [CLAMP_W-1:0] duty;
        logic [CLAMP_W-1:0] dead_time;
        logic               sat;
    } clamp_t;

    // Duty is limited against the already-floored period so the pair stays legal.
    function automatic clamp_t clamp_cfg(
        input logic [CLAMP_W-1:0] period,
        input logic [CLAMP_W-1:0] duty,
        input logic [CLAMP_W-1:0] dead_time,
        input logic [CLAMP_W-1:0] dt_max
    );
        clamp_t r;
        r.period    = (period < CLAMP_W'(2)) ? CLAMP_W'(2) : period;
        r.duty      = (duty > r.period) ? r.period : duty;
        r.dead_time = (dead_time > dt_max) ? dt_max : dead_time;
        r.sat       = (r.period != period) || (r.duty != duty) || (r.dead_time != dead_time);
        return r;
    endfunction

endpackage

// File: rtl/pwm_cfg_shadow.sv
// Shadow registers, pending flags and the commit/clamp datapath that drives
// the active PWM configuration.
module pwm_cfg_shadow
    import pwm_cfg_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int DT_MAX = DEF_DT_MAX
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ctl_acc,
    input  logic [W-1:0] ctl_duty,
    input  logic         host_acc,
    input  logic [W-1:0] host_period,
    input  logic [W-1:0] host_duty,
    input  logic [W-1:0] host_dead_time,
    input  logic         host_enable,
    input  logic         immediate,
    input  logic         boundary,
    output logic         pending,
    output logic         host_pending,
    output logic         shadow_enable,
    output logic         merged_enable,
    output logic [W-1:0] period,
    output logic [W-1:0] duty,
    output logic [W-1:0] dead_time,
    output logic         commit,
    output logic         clamped
);

    logic [W-1:0] sh_period, sh_duty, sh_dead_time;
    logic         sh_enable;
    logic [W-1:0] mg_period, mg_duty, mg_dead_time;
    logic         mg_enable;
    logic [W-1:0] src_period, src_duty, src_dead_time;
    logic         acc_any;
    logic         fire;
    clamp_t       cl;

    assign acc_any       = ctl_acc || host_acc;
    assign shadow_enable = sh_enable;
    assign merged_enable = mg_enable;

    // Shadow as it will look after this cycle's accepts; ctl overrides host duty.
    // NOTE: every output of an always_comb gets a default first so no path infers a latch.
    always_comb begin
        mg_period    = sh_period;
        mg_duty      = sh_duty;
        mg_dead_time = sh_dead_time;
        mg_enable    = sh_enable;
        if (host_acc) begin
            mg_period    = host_period;
            mg_duty      = host_duty;
            mg_dead_time = host_dead_time;
            mg_enable    = host_enable;
        end
        if (ctl_acc) begin
            mg_duty = ctl_duty;
        end
    end

    // When stopped the fresh write commits directly; at a boundary the old shadow does,
    // so a write landing on the boundary edge waits for the next period.
    always_comb begin
        src_period    = immediate ? mg_period    : sh_period;
        src_duty      = immediate ? mg_duty      : sh_duty;
        src_dead_time = immediate ? mg_dead_time : sh_dead_time;
        fire          = immediate ? (acc_any || pending) : boundary;
        cl            = clamp_cfg(CLAMP_W'(src_period), CLAMP_W'(src_duty),
                                  CLAMP_W'(src_dead_time), CLAMP_W'(DT_MAX));
    end

    // NOTE: synchronous reset clears the shadow along with the outputs, so a reset
    // mid-operation discards any queued update instead of committing it later.
    // NOTE: all state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_period    <= '0;
            sh_duty      <= '0;
            sh_dead_time <= '0;
            sh_enable    <= 1'b0;
            pending      <= 1'b0;
            host_pending <= 1'b0;
            period       <= '0;
            duty         <= '0;
            dead_time    <= '0;
            commit       <= 1'b0;
            clamped      <= 1'b0;
        end else begin
            sh_period    <= mg_period;
            sh_duty      <= mg_duty;
            sh_dead_time <= mg_dead_time;
            sh_enable    <= mg_enable;
            commit       <= fire;

            if (fire) begin
                period    <= W'(cl.period);
                duty      <= W'(cl.duty);
                dead_time <= W'(cl.dead_time);
                if (cl.sat) begin
                    clamped <= 1'b1;
                end
            end

            if (immediate) begin
                pending      <= 1'b0;
                host_pending <= 1'b0;
            end else if (boundary) begin
                pending      <= acc_any;
                host_pending <= host_acc;
            end else begin
                pending      <= pending || acc_any;
                host_pending <= host_pending || host_acc;
            end
        end
    end

endmodule

// File: rtl/pwm_cfg_ctrl.sv
// PWM configuration controller: arbitrates control-loop and host writes and
// sequences start/stop so config and enable changes land on period boundaries.
module pwm_cfg_ctrl
    import pwm_cfg_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int DT_MAX = DEF_DT_MAX
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ctl_valid,
    output logic         ctl_ready,
    input  logic [W-1:0] ctl_duty,
    input  logic         host_valid,
    output logic         host_ready,
    input  logic [W-1:0] host_period,
    input  logic [W-1:0] host_duty,
    input  logic [W-1:0] host_dead_time,
    input  logic         host_enable,
    input  logic         ovf_trigger,
    output logic [W-1:0] period,
    output logic [W-1:0] duty,
    output logic [W-1:0] dead_time,
    output logic         pwm_enable,
    output logic         ovf_trigger_enable,
    output logic         pending,
    output logic         commit,
    output logic         clamped
);

    state_t state_q, state_d;
    logic   ctl_acc, host_acc, acc_any;
    logic   immediate, boundary;
    logic   host_pending, shadow_enable, merged_enable;

    // ctl wins collisions; a queued host config must commit before the next one.
    assign ctl_ready  = (state_q != S_STOP);
    assign host_ready = !ctl_valid && !host_pending && (state_q != S_STOP);
    assign ctl_acc    = ctl_valid && ctl_ready;
    assign host_acc   = host_valid && host_ready;
    assign acc_any    = ctl_acc || host_acc;

    always_comb begin
        state_d   = state_q;
        immediate = 1'b0;
        boundary  = 1'b0;
        unique case (state_q)
            S_OFF: begin
                immediate = 1'b1;
                if ((acc_any || pending) && merged_enable) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (ovf_trigger) begin
                    boundary = pending;
                    state_d  = (pending && !shadow_enable) ? S_STOP : S_RUN;
                end
            end
            S_RUN: begin
                if (ovf_trigger && pending) begin
                    boundary = 1'b1;
                    if (!shadow_enable) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (ovf_trigger) begin
                    state_d = S_OFF;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    // Enables follow the next state so they rise with a start commit and fall on the draining boundary.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q            <= S_OFF;
            pwm_enable         <= 1'b0;
            ovf_trigger_enable <= 1'b0;
        end else begin
            state_q            <= state_d;
            pwm_enable         <= (state_d != S_OFF);
            ovf_trigger_enable <= (state_d != S_OFF);
        end
    end

    pwm_cfg_shadow #(
        .W      (W),
        .DT_MAX (DT_MAX)
    ) u_shadow (
        .clk            (clk),
        .reset          (reset),
        .ctl_acc        (ctl_acc),
        .ctl_duty       (ctl_duty),
        .host_acc       (host_acc),
        .host_period    (host_period),
        .host_duty      (host_duty),
        .host_dead_time (host_dead_time),
        .host_enable    (host_enable),
        .immediate      (immediate),
        .boundary       (boundary),
        .pending        (pending),
        .host_pending   (host_pending),
        .shadow_enable  (shadow_enable),
        .merged_enable  (merged_enable),
        .period         (period),
        .duty           (duty),
        .dead_time      (dead_time),
        .commit         (commit),
        .clamped        (clamped)
    );

endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
// Self-checking bench for pwm_cfg_ctrl: a run-state model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_pwm_cfg_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         ctl_valid;
    logic         ctl_ready;
    logic [W-1:0] ctl_duty;
    logic         host_valid;
    logic         host_ready;
    logic [W-1:0] host_period;
    logic [W-1:0] host_duty;
    logic [W-1:0] host_dead_time;
    logic         host_enable;
    logic         ovf_trigger;
    logic [W-1:0] period;
    logic [W-1:0] duty;
    logic [W-1:0] dead_time;
    logic         pwm_enable;
    logic         ovf_trigger_enable;
    logic         pending;
    logic         commit;
    logic         clamped;

    always #5 clk = ~clk;

    pwm_cfg_ctrl #(.W(W), .DT_MAX(255)) dut (
        .clk                (clk),
        .reset              (reset),
        .ctl_valid          (ctl_valid),
        .ctl_ready          (ctl_ready),
        .ctl_duty           (ctl_duty),
        .host_valid         (host_valid),
        .host_ready         (host_ready),
        .host_period        (host_period),
        .host_duty          (host_duty),
        .host_dead_time     (host_dead_time),
        .host_enable        (host_enable),
        .ovf_trigger        (ovf_trigger),
        .period             (period),
        .duty               (duty),
        .dead_time          (dead_time),
        .pwm_enable         (pwm_enable),
        .ovf_trigger_enable (ovf_trigger_enable),
        .pending            (pending),
        .commit             (commit),
        .clamped            (clamped)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [W-1:0] p;
        logic [W-1:0] d;
        logic [W-1:0] dt;
        logic         en;
    } mcfg_t;

    mcfg_t        m_sh;
    bit           m_pend, m_hpend;
    string        m_phase = "OFF";
    logic [W-1:0] e_p, e_d, e_dt;
    bit           e_commit, e_clamped;
    bit           model_live = 0;

    task automatic model_commit(input mcfg_t c);
        logic [W-1:0] p, d, dt;
        p  = (c.p < 32'd2) ? 32'd2 : c.p;
        d  = (c.d > p) ? p : c.d;
        dt = (c.dt > 32'd255) ? 32'd255 : c.dt;
        if (p != c.p || d != c.d || dt != c.dt) e_clamped = 1;
        e_p      = p;
        e_d      = d;
        e_dt     = dt;
        e_commit = 1;
    endtask

    always @(posedge clk) begin
        mcfg_t nw, prev;
        bit    ca, ha;
        model_live = 1;
        if (!reset) begin
            m_sh      = '0;
            m_pend    = 0;
            m_hpend   = 0;
            m_phase   = "OFF";
            e_p       = '0;
            e_d       = '0;
            e_dt      = '0;
            e_commit  = 0;
            e_clamped = 0;
        end else begin
            ca   = ctl_valid && (m_phase != "STOP");
            ha   = host_valid && !ctl_valid && !m_hpend && (m_phase != "STOP");
            prev = m_sh;
            nw   = m_sh;
            if (ha) nw = {host_period, host_duty, host_dead_time, host_enable};
            if (ca) nw.d = ctl_duty;
            e_commit = 0;
            if (m_phase == "OFF") begin
                if (ca || ha || m_pend) begin
                    model_commit(nw);
                    m_pend  = 0;
                    m_hpend = 0;
                    if (nw.en) m_phase = "START";
                end
            end else if (m_phase == "STOP") begin
                if (ovf_trigger) m_phase = "OFF";
            end else if (ovf_trigger && m_pend) begin
                model_commit(prev);
                m_pend  = ca || ha;
                m_hpend = ha;
                m_phase = prev.en ? "RUN" : "STOP";
            end else begin
                if (ovf_trigger) m_phase = "RUN";
                m_pend  = m_pend || ca || ha;
                m_hpend = m_hpend || ha;
            end
            m_sh = nw;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("m_period", period, e_p);
            check("m_duty", duty, e_d);
            check("m_dead_time", dead_time, e_dt);
            check("m_commit", commit, e_commit);
            check("m_clamped", clamped, e_clamped);
            check("m_pending", pending, m_pend);
            check("m_pwm_enable", pwm_enable, m_phase != "OFF");
            check("m_ovf_en", ovf_trigger_enable, m_phase != "OFF");
            check("m_ctl_ready", ctl_ready, m_phase != "STOP");
            check("m_host_ready", host_ready, !ctl_valid && !m_hpend && (m_phase != "STOP"));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic host_write(input logic [W-1:0] p, input logic [W-1:0] d,
                              input logic [W-1:0] dt, input logic en);
        bit done;
        done           = 0;
        host_valid     = 1;
        host_period    = p;
        host_duty      = d;
        host_dead_time = dt;
        host_enable    = en;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            done = host_ready;
            tick();
        end
        host_valid = 0;
        check("host_accept", done, 1);
    endtask

    task automatic ctl_write(input logic [W-1:0] d);
        ctl_valid = 1;
        ctl_duty  = d;
        tick();
        ctl_valid = 0;
    endtask

    task automatic ovf_pulse();
        ovf_trigger = 1;
        tick();
        ovf_trigger = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        reset          = 0;
        ctl_valid      = 0;
        ctl_duty       = '0;
        host_valid     = 0;
        host_period    = '0;
        host_duty      = '0;
        host_dead_time = '0;
        host_enable    = 0;
        ovf_trigger    = 0;

        repeat (20) tick();
        check("rst_period", period, 0);
        check("rst_pwm_enable", pwm_enable, 0);
        check("rst_commit", commit, 0);
        check("rst_ctl_ready", ctl_ready, 1);
        check("rst_host_ready", host_ready, 1);
        reset = 1;
        tick();

        // start-up: immediate commit in OFF, then START
        host_write(32'd10, 32'd2, 32'd1, 1'b1);
        check("start_period", period, 10);
        check("start_duty", duty, 2);
        check("start_dt", dead_time, 1);
        check("start_commit", commit, 1);
        check("start_pwm_enable", pwm_enable, 1);
        check("start_ovf_en", ovf_trigger_enable, 1);
        tick();
        check("start_commit_gone", commit, 0);
        ovf_pulse();
        check("run_no_commit", commit, 0);
        tick();

        // boundary commit of a ctl duty
        ctl_write(32'd3);
        check("bnd_duty_held", duty, 2);
        check("bnd_pending", pending, 1);
        tick();
        tick();
        check("bnd_duty_still", duty, 2);
        ovf_pulse();
        check("bnd_duty", duty, 3);
        check("bnd_commit", commit, 1);
        check("bnd_pending_clr", pending, 0);
        tick();
        check("bnd_single_pulse", commit, 0);

        // collision: ctl wins, host follows
        ctl_valid      = 1;
        ctl_duty       = 32'd5;
        host_valid     = 1;
        host_period    = 32'd20;
        host_duty      = 32'd5;
        host_dead_time = 32'd1;
        host_enable    = 1;
        #1;
        check("col_host_stalled", host_ready, 0);
        check("col_ctl_ready", ctl_ready, 1);
        tick();
        ctl_valid = 0;
        #1;
        check("col_host_ready", host_ready, 1);
        tick();
        host_valid = 0;
        #1;
        check("col_host_pending", host_ready, 0);
        check("col_period_held", period, 10);
        ovf_pulse();
        check("col_period", period, 20);
        check("col_duty", duty, 5);
        check("col_commit", commit, 1);

        // clamp
        host_write(32'd10, 32'd500, 32'd1000, 1'b1);
        ovf_pulse();
        check("clamp_duty", duty, 10);
        check("clamp_dt", dead_time, 255);
        check("clamp_flag", clamped, 1);
        tick();
        tick();
        check("clamp_sticky", clamped, 1);

        // accept on the boundary edge: old shadow commits, new one stays pending
        ctl_write(32'd6);
        ctl_valid   = 1;
        ctl_duty    = 32'd7;
        ovf_trigger = 1;
        tick();
        ctl_valid   = 0;
        ovf_trigger = 0;
        check("same_edge_duty", duty, 6);
        check("same_edge_pending", pending, 1);
        ovf_pulse();
        check("same_edge_next", duty, 7);

        // period floor
        host_write(32'd0, 32'd5, 32'd0, 1'b1);
        ovf_pulse();
        check("floor_period", period, 2);
        check("floor_duty", duty, 2);

        // stop sequence
        host_write(32'd10, 32'd4, 32'd1, 1'b0);
        ovf_pulse();
        check("stop_commit", commit, 1);
        check("stop_duty", duty, 4);
        check("stop_pwm_still_on", pwm_enable, 1);
        check("stop_ctl_ready", ctl_ready, 0);
        check("stop_host_ready", host_ready, 0);
        tick();
        ovf_pulse();
        check("off_pwm_enable", pwm_enable, 0);
        check("off_ovf_en", ovf_trigger_enable, 0);
        check("off_ctl_ready", ctl_ready, 1);
        ovf_pulse();
        check("off_ovf_ignored", commit, 0);

        // reset mid-RUN with an update pending
        host_write(32'd10, 32'd2, 32'd1, 1'b1);
        ovf_pulse();
        ctl_write(32'd9);
        check("pre_rst_pending", pending, 1);
        reset = 0;
        tick();
        check("mid_rst_duty", duty, 0);
        check("mid_rst_pwm_enable", pwm_enable, 0);
        check("mid_rst_pending", pending, 0);
        check("mid_rst_clamped", clamped, 0);
        reset = 1;
        tick();
        ovf_pulse();
        check("post_rst_commit", commit, 0);
        check("post_rst_duty", duty, 0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
